// File: rtl/fifo_read_packer_pkg.sv
// Shared types and default geometry for the FIFO read-side packer.
// Optional partial-word flush is enabled by defining READER_FLUSH_EN.
package fifo_read_packer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEF_MEMORY_WIDTH = 4;
    localparam int DEF_PACK_RATIO   = 4;

endpackage

// File: rtl/fifo_read_packer_if.sv
// FIFO read port plus wide-word valid/ready output; master side is the packer.
// flush/out_cnt exist only when READER_FLUSH_EN is defined.
interface fifo_read_packer_if
    import fifo_read_packer_pkg::*;
#(
    parameter int MEMORY_WIDTH = DEF_MEMORY_WIDTH,
    parameter int PACK_RATIO   = DEF_PACK_RATIO,
    parameter int CNT_SIZE     = 2
);
    logic                                 fifo_empty;
    logic [MEMORY_WIDTH-1:0]              fifo_rdata;
    logic                                 fifo_r_en;
    logic                                 out_ready;
    logic                                 out_valid;
    logic [MEMORY_WIDTH*PACK_RATIO-1:0]   out_data;
`ifdef READER_FLUSH_EN
    logic                                 flush;
    logic [CNT_SIZE:0]                    out_cnt;

    modport master (
        input  fifo_empty, fifo_rdata, out_ready, flush,
        output fifo_r_en, out_valid, out_data, out_cnt
    );
    modport slave (
        output fifo_empty, fifo_rdata, out_ready, flush,
        input  fifo_r_en, out_valid, out_data, out_cnt
    );
`else
    modport master (
        input  fifo_empty, fifo_rdata, out_ready,
        output fifo_r_en, out_valid, out_data
    );
    modport slave (
        output fifo_empty, fifo_rdata, out_ready,
        input  fifo_r_en, out_valid, out_data
    );
`endif
endinterface

// File: rtl/fifo_synch.sv
// Generic synchronous FIFO: registered rdata valid one cycle after an accepted read.
// Writes when full and reads when empty are ignored; full/empty are pointer-derived.
module fifo_synch #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_en,
    input  logic [WIDTH-1:0] wdata,
    input  logic             r_en,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    always_ff @(posedge clk) begin
        if (w_en && !full) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            rdata <= '0;
        end else begin
            if (w_en && !full) begin
                wptr <= wptr + 1'b1;
            end
            if (r_en && !empty) begin
                rptr  <= rptr + 1'b1;
                rdata <= mem[rptr[AW-1:0]];
            end
        end
    end
endmodule

// File: rtl/fifo_read_packer.sv
// Drains fifo_synch and packs PACK_RATIO entries (first read in the LSBs) into one valid/ready word;
// out_valid rises 2 cycles after the final read, reads stop while a word waits. Flush via READER_FLUSH_EN.
module fifo_read_packer
    import fifo_read_packer_pkg::*;
#(
    parameter int MEMORY_WIDTH = DEF_MEMORY_WIDTH,
    parameter int PACK_RATIO   = DEF_PACK_RATIO,
    parameter int CNT_SIZE     = 2
) (
    input  logic               clk,
    input  logic               rst,
    fifo_read_packer_if.master bus
);
    localparam int OUT_WIDTH = MEMORY_WIDTH * PACK_RATIO;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_SIZE-1:0]   cnt;
    logic                  pend;
    logic [OUT_WIDTH-1:0]  data_q;
    logic [CNT_SIZE:0]     in_use;
    logic                  last_capture;
    logic                  flush_go;
    logic                  r_en;

    // Slots already filled plus the read still in flight bound further requests.
    assign in_use       = {1'b0, cnt} + {{CNT_SIZE{1'b0}}, pend};
    assign last_capture = pend && (cnt == CNT_SIZE'(PACK_RATIO - 1));

`ifdef READER_FLUSH_EN
    assign flush_go = (state == FILL) && bus.flush && !pend && (cnt != '0);
    assign r_en     = (state == FILL) && !bus.fifo_empty && !bus.flush
                      && (in_use < (CNT_SIZE+1)'(PACK_RATIO));
`else
    assign flush_go = 1'b0;
    assign r_en     = (state == FILL) && !bus.fifo_empty
                      && (in_use < (CNT_SIZE+1)'(PACK_RATIO));
`endif

    assign bus.fifo_r_en = r_en;
    assign bus.out_valid = (state == HOLD);
    assign bus.out_data  = data_q;

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (last_capture || flush_go) state_nxt = HOLD;
            HOLD:    if (bus.out_ready)            state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            pend   <= 1'b0;
            data_q <= '0;
        end else begin
            pend <= r_en;
            if (state == FILL) begin
                if (pend) begin
                    for (int k = 0; k < PACK_RATIO; k++) begin
                        if (cnt == CNT_SIZE'(k)) begin
                            data_q[k*MEMORY_WIDTH +: MEMORY_WIDTH] <= bus.fifo_rdata;
                        end
                    end
                    cnt <= last_capture ? '0 : cnt + CNT_SIZE'(1);
                end else if (flush_go) begin
                    cnt <= '0;
                end
            end else if (bus.out_ready) begin
                // Cleared slots make a later flushed word zero-padded.
                data_q <= '0;
            end
        end
    end

`ifdef READER_FLUSH_EN
    logic [CNT_SIZE:0] out_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt_q <= '0;
        end else if (state == FILL) begin
            if (last_capture) begin
                out_cnt_q <= (CNT_SIZE+1)'(PACK_RATIO);
            end else if (flush_go) begin
                out_cnt_q <= {1'b0, cnt};
            end
        end else if (bus.out_ready) begin
            out_cnt_q <= '0;
        end
    end

    assign bus.out_cnt = out_cnt_q;
`endif
endmodule

// File: tb/tb_fifo_read_packer.sv
// Bench: fifo_synch source feeding fifo_read_packer; directed vectors with a word scoreboard.
`timescale 1ns/1ps
module tb_fifo_read_packer;
    localparam int MW = 4;
    localparam int PR = 4;
    localparam int CS = 2;
    localparam int OW = MW * PR;

    typedef struct {
        logic [OW-1:0] data;
        logic [CS:0]   cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          w_en = 1'b0;
    logic [MW-1:0] wdata = '0;
    logic          fifo_full;
    logic          out_ready = 1'b0;
    int            total = 0;
    int            bad = 0;
    exp_t          exp_q[$];
    bit            chk_lat = 1'b1;

    int   cyc = 0;
    int   last_ren = -100;
    int   ren_cnt = 0;
    int   ren_run = 0;
    int   last_run = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    fifo_read_packer_if #(.MEMORY_WIDTH(MW), .PACK_RATIO(PR), .CNT_SIZE(CS)) bus ();

    assign bus.out_ready = out_ready;
`ifdef READER_FLUSH_EN
    logic flush = 1'b0;
    assign bus.flush = flush;
`endif

    fifo_synch #(.WIDTH(MW), .DEPTH(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .w_en  (w_en),
        .wdata (wdata),
        .r_en  (bus.fifo_r_en),
        .rdata (bus.fifo_rdata),
        .full  (fifo_full),
        .empty (bus.fifo_empty)
    );

    fifo_read_packer #(.MEMORY_WIDTH(MW), .PACK_RATIO(PR), .CNT_SIZE(CS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic expect_word(input logic [OW-1:0] d, input logic [CS:0] c);
        exp_t e;
        e.data = d;
        e.cnt  = c;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; leaves the bench at the next posedge+1.
    task automatic fifo_write(input logic [MW-1:0] v);
        check("fifo_not_full", {31'd0, fifo_full}, 0);
        w_en  = 1'b1;
        wdata = v;
        @(posedge clk); #1;
        w_en  = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_sb_empty(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: pops the scoreboard on each handshake, tracks read runs and latency.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            prev_valid = 1'b0;
            ren_run    = 0;
        end else begin
            if (bus.fifo_r_en && bus.fifo_empty) begin
                check("no_read_when_empty", 1, 0);
            end
            if (bus.fifo_r_en) begin
                last_ren = cyc;
                ren_cnt++;
                ren_run++;
            end else begin
                if (ren_run != 0) last_run = ren_run;
                ren_run = 0;
            end
            if (bus.out_valid && !prev_valid && chk_lat) begin
                check("valid_latency", cyc - last_ren, 2);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h want none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", {16'd0, bus.out_data}, {16'd0, e.data});
`ifdef READER_FLUSH_EN
                    check("out_cnt", {29'd0, bus.out_cnt}, {29'd0, e.cnt});
`endif
                end
            end
            prev_valid = bus.out_valid;
        end
    end

    initial begin
        int base;
        int n;

        // Reset state
        step(2);
        check("rst_r_en", {31'd0, bus.fifo_r_en}, 0);
        check("rst_valid", {31'd0, bus.out_valid}, 0);
        check("rst_data", {16'd0, bus.out_data}, 32'h0);
        rst = 1'b0;
        step(1);
        check("idle_valid", {31'd0, bus.out_valid}, 0);
        check("idle_r_en", {31'd0, bus.fifo_r_en}, 0);

        // Single word streamed with consumer ready
        out_ready = 1'b1;
        base = ren_cnt;
        expect_word(16'h4321, 3'd4);
        for (int i = 1; i <= 4; i++) fifo_write(MW'(i));
        wait_sb_empty("word_4321");
        step(2);
        check("reads_word1", ren_cnt - base, 4);
        check("read_run", last_run, 4);

        // Consumer stalled: word must hold, no reads
        out_ready = 1'b0;
        expect_word(16'h4321, 3'd4);
        expect_word(16'h8765, 3'd4);
        for (int i = 1; i <= 8; i++) fifo_write(MW'(i));
        n = 0;
        while (!bus.out_valid && n < 50) begin
            step(1);
            n++;
        end
        check("hold_seen", {31'd0, bus.out_valid}, 1);
        for (int i = 0; i < 5; i++) begin
            check("hold_data", {16'd0, bus.out_data}, 32'h4321);
            check("hold_valid", {31'd0, bus.out_valid}, 1);
            check("hold_no_read", {31'd0, bus.fifo_r_en}, 0);
            step(1);
        end
        out_ready = 1'b1;
        wait_sb_empty("words_4321_8765");

        // Empty mid-fill: stall then resume
        base = ren_cnt;
        expect_word(16'hDCBA, 3'd4);
        fifo_write(4'hA);
        fifo_write(4'hB);
        step(10);
        check("partial_reads", ren_cnt - base, 2);
        check("partial_no_valid", {31'd0, bus.out_valid}, 0);
        check("partial_pending", exp_q.size(), 1);
        fifo_write(4'hC);
        fifo_write(4'hD);
        wait_sb_empty("word_dcba");

        // Reset mid-fill discards partial data
        fifo_write(4'h1);
        fifo_write(4'h2);
        step(6);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mid_rst_valid", {31'd0, bus.out_valid}, 0);
        check("mid_rst_data", {16'd0, bus.out_data}, 32'h0);
        check("mid_rst_r_en", {31'd0, bus.fifo_r_en}, 0);
        expect_word(16'h8765, 3'd4);
        for (int i = 5; i <= 8; i++) fifo_write(MW'(i));
        wait_sb_empty("word_after_rst");

`ifdef READER_FLUSH_EN
        // Flush of a three-entry partial word
        chk_lat = 1'b0;
        expect_word(16'h0987, 3'd3);
        fifo_write(4'h7);
        fifo_write(4'h8);
        fifo_write(4'h9);
        step(6);
        check("pre_flush_valid", {31'd0, bus.out_valid}, 0);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        wait_sb_empty("flush_word");
`endif

        step(3);
        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
